crypto_xperm_ctrl: RTL and testbench

Sequencer and arbiter for the shared combinational xperm8/xperm4 datapath in the scalar crypto unit. Two requesters share the datapath:
- port 0: issue path.
- port 1: crypto microcode sequencer.

The block arbitrates between them, registers operands into an execute stage, and drives the datapath. It buffers results in a small output FIFO with valid/ready back-pressure, and supports pipeline flush.

---
 rtl/crypto_xperm_ctrl.sv | 174 +++++++++++++++++
 tb/tb_crypto_xperm_ctrl.sv | 532 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crypto_xperm_ctrl.sv
// crypto_xperm_ctrl: two-port arbiter, execute stage and result FIFO around the shared xperm8/xperm4 datapath.
// Define CRYPTO_XPERM_RR_ARB_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module crypto_xperm_ctrl #(
    parameter int XLEN          = 64,
    parameter int TRANS_ID_BITS = 3,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     req0_valid_i,
    output logic                     req0_ready_o,
    input  logic                     req0_op_i,
    input  logic [XLEN-1:0]          req0_rs1_i,
    input  logic [XLEN-1:0]          req0_rs2_i,
    input  logic [TRANS_ID_BITS-1:0] req0_trans_id_i,
    input  logic                     req1_valid_i,
    output logic                     req1_ready_o,
    input  logic                     req1_op_i,
    input  logic [XLEN-1:0]          req1_rs1_i,
    input  logic [XLEN-1:0]          req1_rs2_i,
    input  logic [TRANS_ID_BITS-1:0] req1_trans_id_i,
    output logic                     dp_op_o,
    output logic [XLEN-1:0]          dp_rs1_o,
    output logic [XLEN-1:0]          dp_rs2_o,
    input  logic [XLEN-1:0]          dp_result_i,
    output logic                     result_valid_o,
    input  logic                     result_ready_i,
    output logic [XLEN-1:0]          result_o,
    output logic [TRANS_ID_BITS-1:0] result_trans_id_o,
    output logic                     result_src_o,
    output logic                     busy_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t state, state_next;

    logic                     s1_op;
    logic [XLEN-1:0]          s1_rs1;
    logic [XLEN-1:0]          s1_rs2;
    logic [TRANS_ID_BITS-1:0] s1_tag;
    logic                     s1_src;

    logic [XLEN-1:0]          fifo_result [FIFO_DEPTH];
    logic [TRANS_ID_BITS-1:0] fifo_tag    [FIFO_DEPTH];
    logic                     fifo_src    [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr, rd_ptr;
    logic [CNT_W-1:0]         count;

    logic grant0, grant1;
    logic fifo_empty, fifo_full;
    logic pop, drain, accept;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign pop        = ~fifo_empty & result_ready_i;
    // S1 can only retire when the FIFO has room, counting the slot a same-cycle pop frees.
    assign drain      = (state == EXEC) & (~fifo_full | pop) & ~flush_i;
    assign accept     = (req0_valid_i & req0_ready_o) | (req1_valid_i & req1_ready_o);

`ifdef CRYPTO_XPERM_RR_ARB_EN
    logic rr_ptr;

    always_comb begin
        grant0 = req0_valid_i & (~req1_valid_i | ~rr_ptr);
        grant1 = req1_valid_i & (~req0_valid_i | rr_ptr);
    end

    // Preference moves to the port that lost; flush never changes it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr <= 1'b0;
        end else if (accept) begin
            rr_ptr <= grant0;
        end
    end
`else
    always_comb begin
        grant0 = req0_valid_i;
        grant1 = req1_valid_i & ~req0_valid_i;
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Ready is masked by rst_ni so nothing is offered while reset is held.
    always_comb begin
        state_next   = state;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        if (rst_ni && !flush_i && (state == IDLE || drain)) begin
            req0_ready_o = grant0;
            req1_ready_o = grant1;
        end
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = drain ? (accept ? EXEC : IDLE) : STALL;
            STALL:   if (pop) state_next = EXEC;
            default: state_next = IDLE;
        endcase
        if (flush_i) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_op  <= 1'b0;
            s1_rs1 <= '0;
            s1_rs2 <= '0;
            s1_tag <= '0;
            s1_src <= 1'b0;
        end else if (accept) begin
            s1_op  <= grant1 ? req1_op_i       : req0_op_i;
            s1_rs1 <= grant1 ? req1_rs1_i      : req0_rs1_i;
            s1_rs2 <= grant1 ? req1_rs2_i      : req0_rs2_i;
            s1_tag <= grant1 ? req1_trans_id_i : req0_trans_id_i;
            s1_src <= grant1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (drain) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({drain, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Entry storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (drain) begin
            fifo_result[wr_ptr] <= dp_result_i;
            fifo_tag[wr_ptr]    <= s1_tag;
            fifo_src[wr_ptr]    <= s1_src;
        end
    end

    assign dp_op_o           = s1_op;
    assign dp_rs1_o          = s1_rs1;
    assign dp_rs2_o          = s1_rs2;
    assign result_valid_o    = ~fifo_empty;
    assign result_o          = fifo_empty ? '0 : fifo_result[rd_ptr];
    assign result_trans_id_o = fifo_empty ? '0 : fifo_tag[rd_ptr];
    assign result_src_o      = fifo_empty ? 1'b0 : fifo_src[rd_ptr];
    assign busy_o            = (state != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_crypto_xperm_ctrl.sv
// tb_crypto_xperm_ctrl: directed self-checking bench for crypto_xperm_ctrl with a behavioural xperm datapath.
`timescale 1ns/1ps
module tb_crypto_xperm_ctrl;

    localparam int XLEN = 64;
    localparam int TID  = 3;

    typedef struct packed {
        logic [XLEN-1:0] res;
        logic [TID-1:0]  tag;
        logic            src;
    } exp_t;

    logic            clk, rst_n, flush;
    logic            req0_valid, req0_ready, req0_op;
    logic [XLEN-1:0] req0_rs1, req0_rs2;
    logic [TID-1:0]  req0_tag;
    logic            req1_valid, req1_ready, req1_op;
    logic [XLEN-1:0] req1_rs1, req1_rs2;
    logic [TID-1:0]  req1_tag;
    logic            dp_op;
    logic [XLEN-1:0] dp_rs1, dp_rs2, dp_result;
    logic            result_valid, result_ready;
    logic [XLEN-1:0] result;
    logic [TID-1:0]  result_tag;
    logic            result_src, busy;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    crypto_xperm_ctrl #(.XLEN(XLEN), .TRANS_ID_BITS(TID), .FIFO_DEPTH(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_op_i(req0_op),
        .req0_rs1_i(req0_rs1), .req0_rs2_i(req0_rs2), .req0_trans_id_i(req0_tag),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_op_i(req1_op),
        .req1_rs1_i(req1_rs1), .req1_rs2_i(req1_rs2), .req1_trans_id_i(req1_tag),
        .dp_op_o(dp_op), .dp_rs1_o(dp_rs1), .dp_rs2_o(dp_rs2), .dp_result_i(dp_result),
        .result_valid_o(result_valid), .result_ready_i(result_ready), .result_o(result),
        .result_trans_id_o(result_tag), .result_src_o(result_src), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural xperm8/xperm4 standing in for the shared datapath.
    function automatic logic [XLEN-1:0] xperm_model(input logic op, input logic [XLEN-1:0] rs1,
                                                    input logic [XLEN-1:0] rs2);
        logic [XLEN-1:0] r;
        int idx;
        r = '0;
        if (op) begin
            for (int i = 0; i < XLEN / 8; i++) begin
                idx = int'(rs2[i*8 +: 8]);
                if (idx < XLEN / 8) r[i*8 +: 8] = rs1[idx*8 +: 8];
            end
        end else begin
            for (int i = 0; i < XLEN / 4; i++) begin
                idx = int'(rs2[i*4 +: 4]);
                r[i*4 +: 4] = rs1[idx*4 +: 4];
            end
        end
        return r;
    endfunction

    assign dp_result = xperm_model(dp_op, dp_rs1, dp_rs2);

    function automatic logic [XLEN-1:0] rs1_of(input int i);
        return 64'h0F1E2D3C4B5A6978 + 64'(i) * 64'h0000000000011111;
    endfunction

    function automatic logic [XLEN-1:0] rs2_of(input int i);
        return {8{8'(i & 7)}} ^ 64'h0001020304050607;
    endfunction

    function automatic exp_t exp_of(input int i, input logic [TID-1:0] tag, input logic src);
        exp_t e;
        e.res = xperm_model(i[0], rs1_of(i), rs2_of(i));
        e.tag = tag;
        e.src = src;
        return e;
    endfunction

    task automatic drive0(input logic v, input int i, input logic [TID-1:0] tag);
        req0_valid = v;
        req0_op    = i[0];
        req0_rs1   = rs1_of(i);
        req0_rs2   = rs2_of(i);
        req0_tag   = tag;
    endtask

    task automatic drive1(input logic v, input int i, input logic [TID-1:0] tag);
        req1_valid = v;
        req1_op    = i[0];
        req1_rs1   = rs1_of(i);
        req1_rs2   = rs2_of(i);
        req1_tag   = tag;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        result_ready = 1'b0;
        drive0(1'b0, 0, 3'd0);
        drive1(1'b0, 0, 3'd0);
        #3;
        checks++;
        if ({req0_ready, req1_ready, dp_op, dp_rs1, dp_rs2, result_valid, result, result_tag,
             result_src, busy} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got busy=%b rv=%b dp_rs1=%h expected all zero",
                     busy, result_valid, dp_rs1);
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready, busy} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL release_ready: got r0=%b r1=%b busy=%b expected 1 0 0",
                     req0_ready, req1_ready, busy);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_op();
        req0_valid = 1'b1;
        req0_op    = 1'b1;
        req0_rs1   = 64'h0706050403020100;
        req0_rs2   = 64'h0001020304050607;
        req0_tag   = 3'd5;
        result_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_accept: got ready=%b expected 1", req0_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({dp_op, dp_rs1, dp_rs2, result_valid} !== {1'b1, 64'h0706050403020100,
                                                       64'h0001020304050607, 1'b0}) begin
            errors++;
            $display("[TB] FAIL single_exec: got op=%b rs1=%h rs2=%h rv=%b expected 1 %h %h 0",
                     dp_op, dp_rs1, dp_rs2, result_valid, 64'h0706050403020100, 64'h0001020304050607);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({result_valid, result, result_tag, result_src} !== {1'b1, 64'h0001020304050607, 3'd5, 1'b0}) begin
            errors++;
            $display("[TB] FAIL single_result: got rv=%b res=%h tag=%0d src=%b expected 1 %h 5 0",
                     result_valid, result, result_tag, result_src, 64'h0001020304050607);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({result_valid, busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL single_drained: got rv=%b busy=%b expected 0 0", result_valid, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int   next_op = 0;
        int   results = 0;
        int   first_acc = -1, last_acc = -1, first_res = -1, last_res = -1;
        logic acc;
        exp_t e;
        exp_q.delete();
        result_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && results < 8; cyc++) begin
            drive0(next_op < 8, next_op, 3'(next_op));
            @(negedge clk);
            acc = req0_valid & req0_ready;
            if (req0_valid) begin
                checks++;
                if (req0_ready !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL b2b_ready: cycle %0d got %b expected 1", cyc, req0_ready);
                end
            end
            if (acc) begin
                exp_q.push_back(exp_of(next_op, 3'(next_op), 1'b0));
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
            end
            if (result_valid && result_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL b2b_result: got unexpected tag=%0d expected none", result_tag);
                end else begin
                    e = exp_q.pop_front();
                    if ({result, result_tag, result_src} !== e) begin
                        errors++;
                        $display("[TB] FAIL b2b_result: got %h/%0d/%b expected %h/%0d/%b",
                                 result, result_tag, result_src, e.res, e.tag, e.src);
                    end
                end
                if (first_res < 0) first_res = cyc;
                last_res = cyc;
                results++;
            end
            @(posedge clk); #1;
            if (acc) next_op++;
        end
        drive0(1'b0, 0, 3'd0);
        checks++;
        if (results != 8) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d results expected 8", results);
        end
        checks++;
        if (last_acc - first_acc != 7) begin
            errors++;
            $display("[TB] FAIL b2b_accept_span: got %0d expected 7", last_acc - first_acc);
        end
        checks++;
        if (last_res - first_res != 7) begin
            errors++;
            $display("[TB] FAIL b2b_result_span: got %0d expected 7", last_res - first_res);
        end
        checks++;
        if (first_res - first_acc != 2) begin
            errors++;
            $display("[TB] FAIL b2b_latency: got %0d expected 2", first_res - first_acc);
        end
    endtask

    task automatic test_back_pressure();
        int   next_op = 0;
        int   accepts = 0;
        int   results = 0;
        logic acc;
        exp_t e;
        exp_q.delete();
        result_ready = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            drive0(next_op < 4, next_op, 3'(next_op));
            @(negedge clk);
            acc = req0_valid & req0_ready;
            if (acc) begin
                exp_q.push_back(exp_of(next_op, 3'(next_op), 1'b0));
                accepts++;
            end
            @(posedge clk); #1;
            if (acc) next_op++;
        end
        @(negedge clk);
        checks++;
        if (accepts != 3) begin
            errors++;
            $display("[TB] FAIL bp_accepts: got %0d expected 3", accepts);
        end
        checks++;
        if ({req0_valid, req0_ready, busy, result_valid, result_tag} !== {1'b1, 1'b0, 1'b1, 1'b1, 3'd0}) begin
            errors++;
            $display("[TB] FAIL bp_stall: got v=%b r=%b busy=%b rv=%b tag=%0d expected 1 0 1 1 0",
                     req0_valid, req0_ready, busy, result_valid, result_tag);
        end
        @(posedge clk); #1;
        result_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && results < 4; cyc++) begin
            drive0(next_op < 4, next_op, 3'(next_op));
            @(negedge clk);
            acc = req0_valid & req0_ready;
            if (acc) begin
                exp_q.push_back(exp_of(next_op, 3'(next_op), 1'b0));
                accepts++;
            end
            if (result_valid && result_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL bp_result: got unexpected tag=%0d expected none", result_tag);
                end else begin
                    e = exp_q.pop_front();
                    if ({result, result_tag, result_src} !== e || result_tag !== 3'(results)) begin
                        errors++;
                        $display("[TB] FAIL bp_result: got %h/%0d expected %h/%0d",
                                 result, result_tag, e.res, results);
                    end
                end
                results++;
            end
            @(posedge clk); #1;
            if (acc) next_op++;
        end
        drive0(1'b0, 0, 3'd0);
        checks++;
        if (results != 4 || accepts != 4) begin
            errors++;
            $display("[TB] FAIL bp_total: got results=%0d accepts=%0d expected 4 4", results, accepts);
        end
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            checks++;
            if (result_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_no_dup: got rv=%b tag=%0d expected 0", result_valid, result_tag);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_contention();
        int   a = 0, b = 0, g = 0, results = 0, exp_src;
        int   grant_seq[8];
        logic acc0, acc1;
        exp_t e;
        for (int k = 0; k < 8; k++) grant_seq[k] = -1;
        exp_q.delete();
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        result_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && results < 8; cyc++) begin
            drive0(a < 4, a, 3'(a));
            drive1(b < 4, 8 + b, 3'(4 + b));
            @(negedge clk);
            acc0 = req0_valid & req0_ready;
            acc1 = req1_valid & req1_ready;
            checks++;
            if (req0_ready && req1_ready) begin
                errors++;
                $display("[TB] FAIL cont_one_ready: got both ready expected at most one");
            end
            if (acc0) begin
                exp_q.push_back(exp_of(a, 3'(a), 1'b0));
                if (g < 8) grant_seq[g] = 0;
                g++;
            end
            if (acc1) begin
                exp_q.push_back(exp_of(8 + b, 3'(4 + b), 1'b1));
                if (g < 8) grant_seq[g] = 1;
                g++;
            end
            if (result_valid && result_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL cont_result: got unexpected tag=%0d expected none", result_tag);
                end else begin
                    e = exp_q.pop_front();
                    if ({result, result_tag, result_src} !== e) begin
                        errors++;
                        $display("[TB] FAIL cont_result: got %h/%0d/%b expected %h/%0d/%b",
                                 result, result_tag, result_src, e.res, e.tag, e.src);
                    end
                end
                results++;
            end
            @(posedge clk); #1;
            if (acc0) a++;
            if (acc1) b++;
        end
        drive0(1'b0, 0, 3'd0);
        drive1(1'b0, 0, 3'd0);
        checks++;
        if (g != 8 || results != 8) begin
            errors++;
            $display("[TB] FAIL cont_count: got grants=%0d results=%0d expected 8 8", g, results);
        end
        for (int k = 0; k < 8; k++) begin
`ifdef CRYPTO_XPERM_RR_ARB_EN
            exp_src = k % 2;
`else
            exp_src = (k < 4) ? 0 : 1;
`endif
            checks++;
            if (grant_seq[k] != exp_src) begin
                errors++;
                $display("[TB] FAIL cont_grant_order: grant %0d got port %0d expected %0d",
                         k, grant_seq[k], exp_src);
            end
        end
    endtask

    task automatic test_flush();
        int   next_op = 0;
        int   accepts = 0;
        logic acc;
        result_ready = 1'b0;
        for (int cyc = 0; cyc < 10 && accepts < 3; cyc++) begin
            drive0(1'b1, next_op, 3'(next_op));
            @(negedge clk);
            acc = req0_valid & req0_ready;
            @(posedge clk); #1;
            if (acc) begin
                next_op++;
                accepts++;
            end
        end
        checks++;
        if (accepts != 3) begin
            errors++;
            $display("[TB] FAIL flush_setup: got %0d accepts expected 3", accepts);
        end
        flush = 1'b1;
        result_ready = 1'b1;
        req0_valid = 1'b1;
        req0_op    = 1'b0;
        req0_rs1   = 64'hFEDCBA9876543210;
        req0_rs2   = 64'h0123456789ABCDEF;
        req0_tag   = 3'd6;
        @(negedge clk);
        checks++;
        if ({req0_ready, result_valid, busy} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL flush_cycle: got ready=%b rv=%b busy=%b expected 0 1 1",
                     req0_ready, result_valid, busy);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if ({result_valid, busy, req0_ready} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL flush_cleared: got rv=%b busy=%b ready=%b expected 0 0 1",
                     result_valid, busy, req0_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (result_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_latency: got rv=%b expected 0", result_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({result_valid, result, result_tag, result_src} !== {1'b1, 64'h0123456789ABCDEF, 3'd6, 1'b0}) begin
            errors++;
            $display("[TB] FAIL flush_next_op: got rv=%b res=%h tag=%0d expected 1 %h 6",
                     result_valid, result, result_tag, 64'h0123456789ABCDEF);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({result_valid, busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL flush_no_stale: got rv=%b tag=%0d busy=%b expected 0 0",
                     result_valid, result_tag, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        int   next_op = 0;
        logic acc;
        exp_t e;
        result_ready = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            drive0(next_op < 4, next_op, 3'(next_op));
            @(negedge clk);
            acc = req0_valid & req0_ready;
            @(posedge clk); #1;
            if (acc) next_op++;
        end
        #1;
        checks++;
        if ({next_op, req0_ready, busy, result_valid} !== {32'd3, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL async_pre_stall: got accepts=%0d ready=%b busy=%b rv=%b expected 3 0 1 1",
                     next_op, req0_ready, busy, result_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({req0_ready, req1_ready, dp_op, dp_rs1, dp_rs2, result_valid, result, result_tag,
             result_src, busy} !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset_outputs: got ready=%b busy=%b rv=%b dp_rs1=%h expected all zero",
                     req0_ready, busy, result_valid, dp_rs1);
        end
        @(negedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if ({busy, result_valid, req0_ready} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL async_release: got busy=%b rv=%b ready=%b expected 0 0 1",
                     busy, result_valid, req0_ready);
        end
        result_ready = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        e = exp_of(3, 3'd3, 1'b0);
        checks++;
        if ({result_valid, result, result_tag, result_src} !== {1'b1, e}) begin
            errors++;
            $display("[TB] FAIL async_after_reset: got rv=%b res=%h tag=%0d expected 1 %h 3",
                     result_valid, result, result_tag, e.res);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish by 100000ns expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_op();
        test_back_to_back();
        test_back_pressure();
        test_contention();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
